// File: rtl/dtw_ref_multi.sv
// rtl/dtw_ref_multi.sv - multi-bank DTW reference memory with masked broadcast load and protected reads
module dtw_ref_multi #(
    parameter int WIDTH            = 16,
    parameter int NUM_CH           = 4,
    parameter int REFMEM_PTR_WIDTH = 12,
    parameter int REF_INIT         = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rs,
    input  logic                               op_mode_in,
    input  logic [NUM_CH-1:0]                  load_mask_in,
    input  logic [REFMEM_PTR_WIDTH-1:0]        ref_len_in,
    input  logic                               abort_in,
    output logic                               busy_out,
    output logic                               err_out,
    output logic [NUM_CH-1:0]                  load_done_out,
    output logic [NUM_CH*REFMEM_PTR_WIDTH-1:0] ref_len_out,
    input  logic [NUM_CH-1:0]                  dtw_done_in,
    input  logic [NUM_CH*REFMEM_PTR_WIDTH-1:0] dtw_read_addr_in,
    output logic [NUM_CH*WIDTH-1:0]            ref_data_out,
    output logic                               src_fifo_clear_out,
    output logic                               src_fifo_rden_out,
    input  logic                               src_fifo_empty,
    input  logic [WIDTH-1:0]                   src_fifo_data_in,
    output logic [1:0]                         dbg_state_out
);

    localparam int PW    = REFMEM_PTR_WIDTH;
    localparam int DEPTH = 1 << PW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  load_done_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [NUM_CH-1:0]  act_q;
    logic [PW-1:0]      len_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      ref_len_q [NUM_CH];
    logic               err_q;

    logic [WIDTH-1:0]   mem       [NUM_CH][DEPTH];
    logic [WIDTH-1:0]   rd_data_q [NUM_CH];
    logic [PW-1:0]      rd_addr   [NUM_CH];

    logic start_load, start_read, reject;
    logic wr_en, wr_last;

    // Bank contents for REF_INIT=1 come from the RAM's own initialisation image;
    // load status still starts empty so no bank is readable until loaded.
    generate
        if (REF_INIT != 0) begin : g_ref_init
        end
    endgenerate

    // A write happens only in LOAD with data available; abort suppresses it.
    assign wr_en   = (state_q == S_LOAD) && !src_fifo_empty && !abort_in;
    assign wr_last = wr_en && (wr_ptr_q == len_q - 1'b1);

    // Next-state and FIFO/status outputs; start requests are only honoured in IDLE.
    always_comb begin
        state_d            = state_q;
        busy_out           = 1'b0;
        src_fifo_clear_out = 1'b0;
        src_fifo_rden_out  = 1'b0;
        start_load         = 1'b0;
        start_read         = 1'b0;
        reject             = 1'b0;
        case (state_q)
            S_IDLE: begin
                src_fifo_clear_out = 1'b1;
                if (rs) begin
                    if (op_mode_in) begin
                        if ((|load_mask_in) && (|ref_len_in)) begin
                            start_load = 1'b1;
                            state_d    = S_LOAD;
                        end else begin
                            reject = 1'b1;
                        end
                    end else if (|load_done_q) begin
                        start_read = 1'b1;
                        state_d    = S_READ;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                busy_out          = 1'b1;
                src_fifo_rden_out = !src_fifo_empty;
                if (abort_in || wr_last) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                busy_out = 1'b1;
                if ((act_q & ~dtw_done_in) == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, load bookkeeping and per-bank status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            load_done_q <= '0;
            mask_q      <= '0;
            act_q       <= '0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            err_q       <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                ref_len_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (start_load) begin
                mask_q      <= load_mask_in;
                len_q       <= ref_len_in;
                wr_ptr_q    <= '0;
                load_done_q <= load_done_q & ~load_mask_in;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (wr_last) begin
                load_done_q <= load_done_q | mask_q;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mask_q[c]) begin
                        ref_len_q[c] <= len_q;
                    end
                end
            end
            if (start_read) begin
                act_q <= load_done_q;
            end else if (state_q == S_READ) begin
                act_q <= act_q & ~dtw_done_in;
            end
        end
    end

    // Broadcast write of the current FIFO word into every targeted bank.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && mask_q[c]) begin
                mem[c][wr_ptr_q] <= src_fifo_data_in;
            end
        end
    end

    // Unpack per-core read addresses.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rd_addr[c] = dtw_read_addr_in[c*PW +: PW];
        end
    end

    // Registered per-core reads; unloaded banks and addresses past the stored length read as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_data_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (load_done_q[c] && (rd_addr[c] < ref_len_q[c])) begin
                    rd_data_q[c] <= mem[c][rd_addr[c]];
                end else begin
                    rd_data_q[c] <= '0;
                end
            end
        end
    end

    // Pack per-channel outputs onto the flat buses.
    always_comb begin
        ref_data_out = '0;
        ref_len_out  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ref_data_out[c*WIDTH +: WIDTH] = rd_data_q[c];
            ref_len_out[c*PW +: PW]        = ref_len_q[c];
        end
    end

    assign load_done_out = load_done_q;
    assign err_out       = err_q;
    assign dbg_state_out = state_q;

endmodule

// File: tb/tb_dtw_ref_multi.sv
// tb/tb_dtw_ref_multi.sv - self-checking bench for dtw_ref_multi
module tb_dtw_ref_multi;

    localparam int W = 16;
    localparam int N = 4;
    localparam int P = 12;

    logic           clk;
    logic           rst_n;
    logic           rs;
    logic           op_mode_in;
    logic [N-1:0]   load_mask_in;
    logic [P-1:0]   ref_len_in;
    logic           abort_in;
    logic           busy_out;
    logic           err_out;
    logic [N-1:0]   load_done_out;
    logic [N*P-1:0] ref_len_out;
    logic [N-1:0]   dtw_done_in;
    logic [N*P-1:0] rd_addr_bus;
    logic [N*W-1:0] ref_data_out;
    logic           src_fifo_clear_out;
    logic           src_fifo_rden_out;
    logic           src_fifo_empty;
    logic [W-1:0]   src_fifo_data;
    logic [1:0]     dbg_state_out;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [W-1:0] fifo [$];

    dtw_ref_multi #(.WIDTH(W), .NUM_CH(N), .REFMEM_PTR_WIDTH(P), .REF_INIT(0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rs                (rs),
        .op_mode_in        (op_mode_in),
        .load_mask_in      (load_mask_in),
        .ref_len_in        (ref_len_in),
        .abort_in          (abort_in),
        .busy_out          (busy_out),
        .err_out           (err_out),
        .load_done_out     (load_done_out),
        .ref_len_out       (ref_len_out),
        .dtw_done_in       (dtw_done_in),
        .dtw_read_addr_in  (rd_addr_bus),
        .ref_data_out      (ref_data_out),
        .src_fifo_clear_out(src_fifo_clear_out),
        .src_fifo_rden_out (src_fifo_rden_out),
        .src_fifo_empty    (src_fifo_empty),
        .src_fifo_data_in  (src_fifo_data),
        .dbg_state_out     (dbg_state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- source FIFO model ----------------
    task automatic refresh();
        src_fifo_empty = (fifo.size() == 0);
        src_fifo_data  = (fifo.size() == 0) ? '0 : fifo[0];
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    initial begin
        logic pop_p, clr_p;
        refresh();
        forever begin
            @(negedge clk);
            pop_p = src_fifo_rden_out && !src_fifo_empty;
            clr_p = src_fifo_clear_out;
            @(posedge clk);
            #1;
            if (clr_p) fifo.delete();
            else if (pop_p) begin
                void'(fifo.pop_front());
                pops++;
            end
            refresh();
        end
    end

    // ---------------- behavioural reference model ----------------
    int           m_state;
    logic [N-1:0] m_ld, m_act, m_mask;
    logic [P-1:0] m_len [N];
    logic [P-1:0] m_llen, m_ptr;
    logic [W-1:0] m_rd [N];
    logic         m_err;
    logic [W-1:0] m_mem [N][1<<P];

    task automatic model_reset();
        m_state = 0; m_ld = '0; m_act = '0; m_mask = '0;
        m_llen = '0; m_ptr = '0; m_err = 1'b0;
        for (int c = 0; c < N; c++) begin
            m_len[c] = '0;
            m_rd[c]  = '0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            logic [P-1:0] a;
            a = rd_addr_bus[c*P +: P];
            m_rd[c] = (m_ld[c] && a < m_len[c]) ? m_mem[c][a] : '0;
        end
        m_err = 1'b0;
        if (m_state == 0) begin
            if (rs) begin
                if (op_mode_in) begin
                    if (load_mask_in != 0 && ref_len_in != 0) begin
                        m_mask  = load_mask_in;
                        m_llen  = ref_len_in;
                        m_ld    = m_ld & ~load_mask_in;
                        m_ptr   = '0;
                        m_state = 1;
                    end else m_err = 1'b1;
                end else if (m_ld != 0) begin
                    m_act   = m_ld;
                    m_state = 2;
                end else m_err = 1'b1;
            end
        end else if (m_state == 1) begin
            if (abort_in) m_state = 0;
            else if (!src_fifo_empty) begin
                for (int c = 0; c < N; c++)
                    if (m_mask[c]) m_mem[c][m_ptr] = src_fifo_data;
                if (int'(m_ptr) == int'(m_llen) - 1) begin
                    m_ld = m_ld | m_mask;
                    for (int c = 0; c < N; c++)
                        if (m_mask[c]) m_len[c] = m_llen;
                    m_state = 0;
                end
                m_ptr = m_ptr + 1'b1;
            end
        end else begin
            m_act = m_act & ~dtw_done_in;
            if (m_act == 0) m_state = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy", busy_out, (m_state == 1 || m_state == 2));
            check("clear", src_fifo_clear_out, (m_state == 0));
            check("rden", src_fifo_rden_out, (m_state == 1) && !src_fifo_empty);
            check("state", dbg_state_out, m_state);
            check("err", err_out, m_err);
            check("load_done", load_done_out, m_ld);
            for (int c = 0; c < N; c++) begin
                check("ref_len", ref_len_out[c*P +: P], m_len[c]);
                check("ref_data", ref_data_out[c*W +: W], m_rd[c]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start(input logic mode, input logic [N-1:0] mask, input logic [P-1:0] len);
        rs = 1'b1; op_mode_in = mode; load_mask_in = mask; ref_len_in = len;
        tick();
        rs = 1'b0; op_mode_in = 1'b0; load_mask_in = '0; ref_len_in = '0;
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!busy_out) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_idle_timeout", ok, 1'b1);
    endtask

    task automatic set_addr_all(input logic [P-1:0] a);
        for (int c = 0; c < N; c++) rd_addr_bus[c*P +: P] = a;
    endtask

    initial begin
        rst_n = 1'b0; rs = 1'b0; op_mode_in = 1'b0; load_mask_in = '0;
        ref_len_in = '0; abort_in = 1'b0; dtw_done_in = '0; rd_addr_bus = '0;
        do_reset();

        // reset state
        check("rst_load_done", load_done_out, 4'b0000);
        check("rst_clear", src_fifo_clear_out, 1'b1);
        check("rst_busy", busy_out, 1'b0);
        check("rst_ref_data", ref_data_out, 64'h0);

        // single bank load, 10..14
        pops = 0;
        start(1'b1, 4'b0001, 12'd5);
        for (int i = 0; i < 5; i++) push(W'(10 + i));
        wait_idle(40);
        check("t1_pops", pops, 5);
        check("t1_load_done", load_done_out, 4'b0001);
        check("t1_len0", ref_len_out[P-1:0], 12'd5);
        for (int a = 0; a < 6; a++) begin
            rd_addr_bus[P-1:0] = P'(a);
            tick();
            check("t1_read", ref_data_out[W-1:0], (a < 5) ? 64'(10 + a) : 64'h0);
        end

        // rejected starts
        do_reset();
        pops = 0;
        start(1'b0, 4'b0000, 12'd0);
        check("err_read_pulse", err_out, 1'b1);
        check("err_read_state", dbg_state_out, 2'd0);
        tick();
        check("err_read_single", err_out, 1'b0);
        start(1'b1, 4'b0000, 12'd4);
        check("err_mask_pulse", err_out, 1'b1);
        tick();
        check("err_mask_single", err_out, 1'b0);
        start(1'b1, 4'b0001, 12'd0);
        check("err_len_pulse", err_out, 1'b1);
        check("err_len_state", dbg_state_out, 2'd0);
        tick();
        check("err_len_single", err_out, 1'b0);
        check("err_pops", pops, 0);

        // broadcast load with mid-load stall
        start(1'b1, 4'b1010, 12'd3);
        push(16'd7);
        for (int i = 0; i < 5; i++) tick();
        check("t2_stall_state", dbg_state_out, 2'd1);
        check("t2_stall_busy", busy_out, 1'b1);
        push(16'd8);
        push(16'd9);
        wait_idle(40);
        check("t2_load_done", load_done_out, 4'b1010);
        check("t2_len1", ref_len_out[2*P-1:P], 12'd3);
        check("t2_len3", ref_len_out[4*P-1:3*P], 12'd3);
        for (int a = 0; a < 3; a++) begin
            set_addr_all(P'(a));
            tick();
            check("t2_bank0", ref_data_out[W-1:0], 64'h0);
            check("t2_bank1", ref_data_out[2*W-1:W], 64'(7 + a));
            check("t2_bank2", ref_data_out[3*W-1:2*W], 64'h0);
            check("t2_bank3", ref_data_out[4*W-1:3*W], 64'(7 + a));
        end

        // abort after 3 writes
        pops = 0;
        start(1'b1, 4'b0100, 12'd8);
        for (int i = 0; i < 8; i++) push(W'(100 + i));
        for (int i = 0; i < 20; i++) begin
            if (pops >= 3) break;
            tick();
        end
        check("abort_pops_before", pops, 3);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("abort_state", dbg_state_out, 2'd0);
        check("abort_load_done", load_done_out, 4'b1010);
        check("abort_clear", src_fifo_clear_out, 1'b1);
        check("abort_len2", ref_len_out[3*P-1:2*P], 12'd0);
        tick();

        // READ session with done pulses
        do_reset();
        start(1'b1, 4'b0011, 12'd2);
        push(16'd21);
        push(16'd22);
        wait_idle(40);
        check("t5_load_done", load_done_out, 4'b0011);
        start(1'b0, 4'b0000, 12'd0);
        check("t5_read_state", dbg_state_out, 2'd2);
        dtw_done_in = 4'b0100;
        tick();
        dtw_done_in = 4'b0000;
        check("t5_ignored_done", dbg_state_out, 2'd2);
        check("t5_busy_hold", busy_out, 1'b1);
        dtw_done_in = 4'b0011;
        tick();
        dtw_done_in = 4'b0000;
        check("t5_idle", dbg_state_out, 2'd0);
        check("t5_busy_drop", busy_out, 1'b0);
        tick();

        // asynchronous reset mid-load
        start(1'b1, 4'b0001, 12'd4);
        push(16'd55);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_load_done", load_done_out, 4'b0000);
        check("arst_busy", busy_out, 1'b0);
        check("arst_clear", src_fifo_clear_out, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtw_ref_multi.md
Name: dtw_ref_multi

Overview:
Multi-channel reference memory manager for the multi-accelerator DTW array. It holds NUM_CH independent reference banks, one per DTW core. A single source FIFO loads the banks, either into one bank or broadcast to several, selected by mask. Each core then reads its bank concurrently through its own address port. Compared with the single-channel loader, it adds per-channel load status, stored per-bank lengths, load abort, error reporting and out-of-range read protection.

Parameters:
WIDTH, 16, reference sample width
NUM_CH, 4, number of banks / DTW cores (1..16)
REFMEM_PTR_WIDTH, 12, bank address width; bank depth = 2^REFMEM_PTR_WIDTH
REF_INIT, 0, 1 = banks preloaded from init file; load_done still resets to 0

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
rs  in  1  start pulse, sampled in IDLE only
op_mode_in  in  1  0 = normal/read, 1 = load reference
load_mask_in  in  NUM_CH  banks targeted by a load
ref_len_in  in  REFMEM_PTR_WIDTH  words to load
abort_in  in  1  abort an in-progress load
busy_out  out  1  high in LOAD and READ
err_out  out  1  one-cycle pulse on a rejected start
load_done_out  out  NUM_CH  per-bank valid-reference flag
ref_len_out  out  NUM_CH*REFMEM_PTR_WIDTH  stored length per bank; channel c at [c*PTR +: PTR]
dtw_done_in  in  NUM_CH  per-core finished pulse
dtw_read_addr_in  in  NUM_CH*REFMEM_PTR_WIDTH  per-core read address
ref_data_out  out  NUM_CH*WIDTH  per-core read data
src_fifo_clear_out  out  1  source FIFO clear
src_fifo_rden_out  out  1  source FIFO read enable
src_fifo_empty  in  1  source FIFO empty
src_fifo_data_in  in  WIDTH  source FIFO data, first-word-fall-through
dbg_state_out  out  2  FSM state

Behaviour:
- Reset values: state IDLE, load_done_out = 0, ref_len_out = 0, ref_data_out = 0, err_out = 0, busy_out = 0, internal wr_ptr = 0, active mask = 0. src_fifo_clear_out is 1 because the block is in IDLE. Reset mid-LOAD or mid-READ discards all status; bank contents are left undefined.
- States: IDLE = 0, LOAD = 1, READ = 2. Encoding 3 is illegal and returns to IDLE on the next clock.
- IDLE: src_fifo_clear_out = 1, src_fifo_rden_out = 0, busy_out = 0.
  - rs & op_mode_in = 1, load_mask_in != 0 and ref_len_in != 0:
    - latch mask and length;
    - clear load_done for the masked banks on the same edge;
    - wr_ptr <= 0; go to LOAD.
  - rs & op_mode_in = 1 with mask = 0 or length = 0: err_out pulses for 1 cycle; stay in IDLE.
  - rs & op_mode_in = 0 with load_done_out != 0: active mask <= load_done_out; go to READ.
  - rs & op_mode_in = 0 with load_done_out = 0: err_out pulses; stay in IDLE.
- LOAD: busy_out = 1, src_fifo_clear_out = 0.
  - src_fifo_rden_out = !src_fifo_empty (combinational).
  - Each cycle with rden & !empty, src_fifo_data_in is written at wr_ptr into every latched-mask bank, and wr_ptr increments.
  - On the write with wr_ptr = len-1:
    - set load_done for the masked banks;
    - ref_len_out[c] <= len for those banks;
    - go to IDLE next cycle.
  - Exactly len words are consumed; no extra FIFO read occurs.
  - An empty FIFO stalls the load indefinitely.
  - abort_in (priority over a write in the same cycle):
    - no write that cycle; go to IDLE;
    - masked load_done stays 0; ref_len_out is unchanged;
    - the IDLE clear flushes the remaining FIFO words.
- READ: busy_out = 1, rden = 0, clear = 0.
  - dtw_done_in[c] clears active bit c. Done pulses for inactive channels are ignored.
  - Go to IDLE on the cycle after the active mask becomes 0.
  - Simultaneous done pulses on several channels are all honoured.
- rs is ignored outside IDLE.
- Read ports are independent of state. ref_data_out[c] is registered with 1-cycle latency: it equals bank_c[addr] when addr < ref_len_out[c] and load_done[c] = 1, and 0 otherwise.
- A read and a write to the same bank and address in the same cycle return the old data (read-first).
- Widths: wr_ptr is REFMEM_PTR_WIDTH bits. The largest loadable length is 2^PTR-1, so wr_ptr never wraps.

Test Plan:
- Reset, then load mask = 4'b0001, len = 5, FIFO holds 10..14. Expect 5 rden beats, load_done = 0001, ref_len_out[0] = 5. Core 0 reads addr 0..4 and gets 10..14, each one cycle after its address. Addr 5 returns 0.
- Broadcast: mask = 4'b1010, len = 3, data 7, 8, 9, with the FIFO going empty for 4 cycles mid-load. Expect the load to stall, then complete. Banks 1 and 3 both return 7, 8, 9; banks 0 and 2 return 0.
- Start rs with mode = 1 and mask = 0, and separately with len = 0. Expect a single-cycle err_out each time, the state stays IDLE, and no FIFO read occurs. Read start with load_done = 0 gives err_out.
- Abort: len = 8, assert abort_in after 3 writes. Expect IDLE next cycle, load_done bit unchanged (0), and clear = 1.
- READ with load_done = 0011: pulse dtw_done_in = 0011 in the same cycle. Expect IDLE one cycle later. A done on channel 2 in READ is ignored, and busy_out drops together with the return to IDLE.
- Assert rst_n low mid-load, asynchronously between clock edges. Expect load_done = 0, busy_out = 0 and clear = 1 immediately.
